div8_seq: RTL and testbench

DIV8_SEQ -- requirements
Module: div8_seq

---
 rtl/div8_pkg.sv | 12 +
 rtl/div8_addsub.sv | 19 +
 rtl/div8_seq.sv | 156 +++++++++++++++
 tb/tb_div8_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div8_pkg.sv
// rtl/div8_pkg.sv - shared state encoding and default width for the div8_seq divider
package div8_pkg;

    localparam int DIV8_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div8_addsub.sv
// rtl/div8_addsub.sv - N-bit combinational add/subtract stage with carry (no-borrow) out
module div8_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] y_o,
    output logic         cout_o
);

    logic [N:0] sum;

    // Subtraction is a + ~b + 1, so cout_o = 1 means a >= b
    assign sum    = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{N{1'b0}}, sub_i};
    assign y_o    = sum[N-1:0];
    assign cout_o = sum[N];

endmodule

// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential restoring divider, W cycles per op; DIV8_SIGNED_EN adds signed_op
module div8_seq
    import div8_pkg::*;
#(
    parameter int W = DIV8_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
`ifdef DIV8_SIGNED_EN
    input  logic         signed_op,
`endif
    output logic         dz
);

    localparam logic [W-1:0] LAST_ITER = W'(W - 1);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] part_q, part_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic         dz_q, dz_d;
`ifdef DIV8_SIGNED_EN
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;

    function automatic logic [W-1:0] neg2(input logic [W-1:0] x);
        return ~x + 1'b1;
    endfunction
`endif

    // acc_q shifts dividend bits out of its MSB while quotient bits enter at its LSB
    logic [W:0]   trial;
    logic [W:0]   diff;
    logic         no_borrow;
    logic         diff_msb_unused;
    logic [W-1:0] next_part;
    logic [W-1:0] next_acc;

    assign trial = {part_q, acc_q[W-1]};

    div8_addsub #(.N(W + 1)) u_trial (
        .a_i    (trial),
        .b_i    ({1'b0, dvs_q}),
        .sub_i  (1'b1),
        .y_o    (diff),
        .cout_o (no_borrow)
    );

    assign diff_msb_unused = diff[W];
    assign next_part       = no_borrow ? diff[W-1:0] : trial[W-1:0];
    assign next_acc        = {acc_q[W-2:0], no_borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIV8_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    part_d  = '0;
`ifdef DIV8_SIGNED_EN
                    qneg_d  = signed_op & (dividend[W-1] ^ divisor[W-1]);
                    rneg_d  = signed_op & dividend[W-1];
                    acc_d   = (signed_op && dividend[W-1]) ? neg2(dividend) : dividend;
                    dvs_d   = (signed_op && divisor[W-1]) ? neg2(divisor) : divisor;
`else
                    acc_d   = dividend;
                    dvs_d   = divisor;
`endif
                end
            end
            CALC: begin
                part_d = next_part;
                acc_d  = next_acc;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    dz_d    = (dvs_q == '0);
`ifdef DIV8_SIGNED_EN
                    quo_d   = (dvs_q == '0) ? '1 : (qneg_q ? neg2(next_acc) : next_acc);
                    rem_d   = rneg_q ? neg2(next_part) : next_part;
`else
                    // A zero divisor never borrows, so quo is all ones and rem the dividend
                    quo_d   = next_acc;
                    rem_d   = next_part;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef DIV8_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef DIV8_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quo       = quo_q;
    assign rem       = rem_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div8_seq.sv
// tb/tb_div8_seq.sv - directed self-checking bench for div8_seq (signed vectors with DIV8_SIGNED_EN)
module tb_div8_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         signed_op = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div8_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .rem       (rem),
`ifdef DIV8_SIGNED_EN
        .signed_op (signed_op),
`endif
        .dz        (dz)
    );

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (quo !== 8'h00) begin failures++; $display("FAIL rst_quo got=%h want=00", quo); end
        checks++; if (rem !== 8'h00) begin failures++; $display("FAIL rst_rem got=%h want=00", rem); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL rst_dz got=%b want=0", dz); end
    endtask

    task automatic test_first_accept();
        int lat;
        rst_n = 1'b1;
        start_op(8'd200, 8'd7, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL first_edge_accept in_ready got=%b want=0", in_ready); end
        wait_done(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL lat_200_7 got=%0d want=8", lat); end
        checks++; if (quo !== 8'h1C) begin failures++; $display("FAIL quo_200_7 got=%h want=1c", quo); end
        checks++; if (rem !== 8'h04) begin failures++; $display("FAIL rem_200_7 got=%h want=04", rem); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL dz_200_7 got=%b want=0", dz); end
        handshake();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_after_200_7 got=%b want=1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'd3,   8'hF0};
        logic [W-1:0] vb [4] = '{8'h00, 8'h01, 8'd200, 8'h0F};
        logic [W-1:0] vq [4] = '{8'hFF, 8'hFF, 8'h00,  8'h10};
        logic [W-1:0] vr [4] = '{8'h5A, 8'h00, 8'h03,  8'h00};
        logic         vd [4] = '{1'b1,  1'b0,  1'b0,   1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_done(lat);
            checks++; if (lat !== 8) begin failures++; $display("FAIL vec%0d_lat got=%0d want=8", i, lat); end
            checks++; if (quo !== vq[i]) begin failures++; $display("FAIL vec%0d_quo got=%h want=%h", i, quo, vq[i]); end
            checks++; if (rem !== vr[i]) begin failures++; $display("FAIL vec%0d_rem got=%h want=%h", i, rem, vr[i]); end
            checks++; if (dz !== vd[i]) begin failures++; $display("FAIL vec%0d_dz got=%b want=%b", i, dz, vd[i]); end
            handshake();
            checks++; if (quo !== vq[i]) begin failures++; $display("FAIL vec%0d_idle_quo got=%h want=%h", i, quo, vq[i]); end
        end
    endtask

    task automatic test_hold();
        int lat;
        start_op(8'd50, 8'd6, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL hold_lat got=%0d want=8", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            dividend = 8'd9;
            divisor  = 8'd3;
            @(posedge clk); #1;
            checks++; if (quo !== 8'd8) begin failures++; $display("FAIL hold%0d_quo got=%h want=08", i, quo); end
            checks++; if (rem !== 8'd2) begin failures++; $display("FAIL hold%0d_rem got=%h want=02", i, rem); end
            checks++; if (dz !== 1'b0) begin failures++; $display("FAIL hold%0d_dz got=%b want=0", i, dz); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold%0d_out_valid got=%b want=1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold%0d_in_ready got=%b want=0", i, in_ready); end
        end
        in_valid = 1'b0;
        handshake();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_out_valid got=%b want=0", out_valid); end
        checks++; if (quo !== 8'd8) begin failures++; $display("FAIL hold_idle_quo got=%h want=08", quo); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_pulse_ignored got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(8'd200, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        checks++; if (quo !== 8'h00) begin failures++; $display("FAIL midrst_quo got=%h want=00", quo); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_hold%0d_out_valid got=%b want=0", i, out_valid); end
        end
        rst_n = 1'b1;
        start_op(8'd100, 8'd10, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL post_rst_lat got=%0d want=8", lat); end
        checks++; if (quo !== 8'd10) begin failures++; $display("FAIL post_rst_quo got=%h want=0a", quo); end
        checks++; if (rem !== 8'd0) begin failures++; $display("FAIL post_rst_rem got=%h want=00", rem); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int accepts [$];
        int doubles;
        int lat;
        logic prev_ready;
        doubles   = 0;
        dividend  = 8'd77;
        divisor   = 8'd5;
        signed_op = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 35; cyc++) begin
            prev_ready = in_ready;
            @(posedge clk); #1;
            if (prev_ready) accepts.push_back(cyc);
            if (prev_ready && in_ready) doubles++;
            if (out_valid) begin
                checks++; if (quo !== 8'd15 || rem !== 8'd2) begin failures++; $display("FAIL b2b_result cyc=%0d got=%h/%h want=0f/02", cyc, quo, rem); end
            end
        end
        in_valid = 1'b0;
        checks++; if (accepts.size() !== 4) begin failures++; $display("FAIL b2b_accept_count got=%0d want=4", accepts.size()); end
        checks++; if (doubles !== 0) begin failures++; $display("FAIL b2b_double_accept got=%0d want=0", doubles); end
        for (int i = 1; i < accepts.size(); i++) begin
            checks++; if (accepts[i] - accepts[i-1] !== 10) begin failures++; $display("FAIL b2b_gap%0d got=%0d want=10", i, accepts[i] - accepts[i-1]); end
        end
        wait_done(lat);
        checks++; if (lat < 0) begin failures++; $display("FAIL b2b_drain got=timeout want=done"); end
        out_ready = 1'b0;
        handshake();
    endtask

`ifdef DIV8_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] va [5] = '{8'hF9, 8'h07, 8'h80, 8'h90, 8'hF9};
        logic [W-1:0] vb [5] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h02};
        logic         vs [5] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [W-1:0] vq [5] = '{8'hFD, 8'hFD, 8'h80, 8'hFF, 8'h7C};
        logic [W-1:0] vr [5] = '{8'hFF, 8'h01, 8'h00, 8'h90, 8'h01};
        logic         vd [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_done(lat);
            checks++; if (lat !== 8) begin failures++; $display("FAIL sgn%0d_lat got=%0d want=8", i, lat); end
            checks++; if (quo !== vq[i]) begin failures++; $display("FAIL sgn%0d_quo got=%h want=%h", i, quo, vq[i]); end
            checks++; if (rem !== vr[i]) begin failures++; $display("FAIL sgn%0d_rem got=%h want=%h", i, rem, vr[i]); end
            checks++; if (dz !== vd[i]) begin failures++; $display("FAIL sgn%0d_dz got=%b want=%b", i, dz, vd[i]); end
            handshake();
        end
        signed_op = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_accept();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef DIV8_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
